// File: rtl/ins_loader_pkg.sv
// Shared types for the instruction loader: FSM states and frame field widths.
package ins_loader_pkg;

  localparam int LEN_W  = 16;
  localparam int CSUM_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CSUM   = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  function automatic logic can_start(state_t s);
    return (s == S_IDLE) || (s == S_DONE) || (s == S_ERR);
  endfunction

endpackage

// File: rtl/ins_loader_packer.sv
// Byte packer: assembles four bytes into a little-endian word.
module ins_loader_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_ready_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clr_i) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (en_i) begin
      cnt_d  = cnt_q + 2'd1;
      // Shift right so the first byte lands in [7:0].
      word_d = {byte_i, word_q[31:8]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word_o       = word_q;
  assign word_ready_o = en_i && (cnt_q == 2'd3);

endmodule

// File: rtl/ins_loader.sv
// Instruction-memory loader: framed byte stream in, LE words out,
// XOR checksum check, CPU held until a clean load finishes.
module ins_loader
  import ins_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        mem_write,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded,
  output logic        cpu_hold
);

  state_t state_q, state_d;

  logic [LEN_W-1:0]  len_q, words_q;
  logic [CSUM_W-1:0] acc_q;
  logic [LEN_W-1:0]  n_hdr;
  logic [31:0]       word;
  logic              take, start_ok, word_ready, last_word;

  assign take      = in_valid && in_ready;
  assign start_ok  = start && can_start(state_q);
  assign n_hdr     = {in_byte, len_q[7:0]};
  assign last_word = ({1'b0, words_q} + 17'd1) >= {1'b0, len_q};

  ins_loader_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (start_ok),
    .en_i         (take && (state_q == S_DATA)),
    .byte_i       (in_byte),
    .word_o       (word),
    .word_ready_o (word_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR:
        if (start) state_d = S_LEN_LO;
      S_LEN_LO:
        if (take) state_d = S_LEN_HI;
      S_LEN_HI:
        if (take) begin
          if (n_hdr == '0)
            state_d = S_CSUM;
          else if ({1'b0, n_hdr} > 17'(MAX_WORDS))
            state_d = S_ERR;
          else
            state_d = S_DATA;
        end
      S_DATA:
        if (word_ready) state_d = S_WRITE;
      S_WRITE:
        state_d = last_word ? S_CSUM : S_DATA;
      S_CSUM:
        if (take) state_d = (in_byte == acc_q) ? S_DONE : S_ERR;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    mem_write = 1'b0;
    mem_wd    = '0;
    unique case (state_q)
      S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_WRITE: begin
        busy      = 1'b1;
        mem_write = 1'b1;
        mem_wd    = word;
      end
      default: ;
    endcase
  end

  assign done         = (state_q == S_DONE);
  assign err          = (state_q == S_ERR);
  assign cpu_hold     = (state_q != S_DONE);
  assign words_loaded = words_q;
  assign mem_addr     = BASE_ADDR + {14'd0, words_q, 2'b00};

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      len_q   <= '0;
      words_q <= '0;
      acc_q   <= '0;
    end else begin
      if (take && state_q != S_CSUM) acc_q <= acc_q ^ in_byte;
      if (take && state_q == S_LEN_LO) len_q[7:0]  <= in_byte;
      if (take && state_q == S_LEN_HI) len_q[15:8] <= in_byte;
      if (state_q == S_WRITE) words_q <= words_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_ins_loader.sv
// Directed bench for ins_loader: frames with hand-computed
// checksums, write log captured from the memory port.
module tb_ins_loader;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [7:0]  in_byte;
  logic        in_ready, mem_write, busy, done, err, cpu_hold;
  logic [31:0] mem_addr, mem_wd;
  logic [15:0] words_loaded;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  always #5 clk = ~clk;

  ins_loader #(.BASE_ADDR(BASE), .MAX_WORDS(1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_byte      (in_byte),
    .in_ready     (in_ready),
    .mem_addr     (mem_addr),
    .mem_wd       (mem_wd),
    .mem_write    (mem_write),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded),
    .cpu_hold     (cpu_hold)
  );

  always @(negedge clk)
    if (mem_write) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wd);
    end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && t < 20) begin
      tick();
      t++;
    end
    if (t >= 20) chk("ready_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input string tag);
    send(w[7:0]);
    send(w[15:8]);
    send(w[23:16]);
    send(w[31:24]);
    chk({tag, "_wr_lat"}, {31'd0, mem_write}, 32'd1);
    chk({tag, "_rdy_wr"}, {31'd0, in_ready}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
    tick();
    rst = 1'b0;
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_wr", {31'd0, mem_write}, 32'd0);
    chk("rst_addr", mem_addr, BASE);
    chk("rst_wd", mem_wd, 32'd0);
    chk("rst_flags", {28'd0, busy, done, err, cpu_hold}, 32'h1);
    chk("rst_words", {16'd0, words_loaded}, 32'd0);

    // Single word; start with in_valid high must not consume a byte.
    in_valid = 1'b1; in_byte = 8'h01;
    pulse_start();
    chk("t2_busy", {31'd0, busy}, 32'd1);
    send(8'h01); send(8'h00);
    send_word(32'h0000_0013, "t2");
    send(8'h12);
    chk("t2_nwr", wa.size(), 32'd1);
    if (wa.size() == 1) begin
      chk("t2_addr", wa[0], BASE);
      chk("t2_wd", wd[0], 32'h0000_0013);
    end
    chk("t2_flags", {28'd0, busy, done, err, cpu_hold}, 32'h4);
    chk("t2_words", {16'd0, words_loaded}, 32'd1);
    wa.delete(); wd.delete();

    // Three words, checksum 8B.
    pulse_start();
    chk("t3_clr", {29'd0, done, err, cpu_hold}, 32'h1);
    send(8'h03); send(8'h00);
    send_word(32'h1122_3344, "t3a");
    send_word(32'h5566_7788, "t3b");
    send_word(32'hA5A5_A5A5, "t3c");
    send(8'h8B);
    chk("t3_nwr", wa.size(), 32'd3);
    if (wa.size() == 3) begin
      chk("t3_a0", wa[0], BASE);
      chk("t3_a1", wa[1], BASE + 32'd4);
      chk("t3_a2", wa[2], BASE + 32'd8);
      chk("t3_d0", wd[0], 32'h1122_3344);
      chk("t3_d1", wd[1], 32'h5566_7788);
      chk("t3_d2", wd[2], 32'hA5A5_A5A5);
    end
    chk("t3_done", {30'd0, done, err}, 32'h2);
    chk("t3_words", {16'd0, words_loaded}, 32'd3);
    wa.delete(); wd.delete();

    // Empty program: good and bad checksum.
    pulse_start();
    send(8'h00); send(8'h00); send(8'h00);
    chk("t4_done", {29'd0, done, err, cpu_hold}, 32'h4);
    pulse_start();
    send(8'h00); send(8'h00); send(8'h5A);
    chk("t4_err", {29'd0, done, err, cpu_hold}, 32'h3);
    chk("t4_nwr", wa.size(), 32'd0);

    // Oversized header: N = 1025.
    pulse_start();
    send(8'h01); send(8'h04);
    chk("t5_err", {28'd0, busy, done, err, cpu_hold}, 32'h3);
    chk("t5_rdy", {31'd0, in_ready}, 32'd0);
    chk("t5_nwr", wa.size(), 32'd0);
    pulse_start();
    chk("t5_clr", {28'd0, busy, done, err, cpu_hold}, 32'h9);
    chk("t5_rdy2", {31'd0, in_ready}, 32'd1);

    // Reset mid-word aborts with no partial write.
    send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_idle", {28'd0, busy, done, err, cpu_hold}, 32'h1);
    chk("t6_rdy", {31'd0, in_ready}, 32'd0);
    chk("t6_words", {16'd0, words_loaded}, 32'd0);
    repeat (3) tick();
    chk("t6_nwr0", wa.size(), 32'd0);

    // Start while busy is ignored.
    pulse_start();
    send(8'h01); send(8'h00);
    send(8'h01);
    pulse_start();
    chk("t6_busy", {31'd0, busy}, 32'd1);
    send(8'h02); send(8'h03); send(8'h04);
    chk("t6_wr", {31'd0, mem_write}, 32'd1);
    send(8'h05);
    chk("t6_nwr", wa.size(), 32'd1);
    if (wa.size() == 1)
      chk("t6_wd", wd[0], 32'h0403_0201);
    chk("t6_done", {29'd0, done, err, cpu_hold}, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
